// File: rtl/bitmap_slice_feeder.sv
// Transmit side of the cmpalu bitmap-slice interface: loads a ROWS x COLS bitmap
// from memory, then serves column, top-row and bottom-row slice streams on request.
module bitmap_slice_feeder #(
    parameter int ROWS = 64,
    parameter int COLS = 24,
    parameter int AW   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            go,
    input  logic [AW-1:0]   base_addr,
    output logic            mem_rd,
    output logic [AW-1:0]   mem_addr,
    input  logic [COLS-1:0] mem_rdata,
    output logic            alu_start,
    output logic [ROWS-1:0] bitcolumn,
    output logic [COLS-1:0] bitrowtop,
    output logic [COLS-1:0] bitrowbot,
    output logic            nextcolumnready,
    output logic            nextrowtopready,
    output logic            nextrowbotready,
    output logic            lastcolumn,
    input  logic            nextcolumn,
    input  logic            nextrowtop,
    input  logic            nextrowbot,
    input  logic            alu_done,
    input  logic [15:0]     alu_result,
    output logic [15:0]     result,
    output logic            done
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    typedef enum logic [1:0] {IDLE, LOAD, START, SERVE} state_t;

    state_t                   state;
    logic [ROWS-1:0][COLS-1:0] bmp;
    logic [RW-1:0]            rd_row, wr_row;
    logic                     wr_vld;
    logic [CW-1:0]            col_idx, col_nx, col_sel;
    logic [RW-1:0]            top_idx, bot_idx, top_nx, bot_nx;
    logic                     col_arm, top_arm, bot_arm;
    logic                     col_more, top_more, bot_more;
    logic [ROWS-1:0]          col_data;

    assign col_nx   = col_idx + 1'b1;
    assign top_nx   = top_idx + 1'b1;
    assign bot_nx   = bot_idx - 1'b1;
    assign col_more = (col_idx != CW'(COLS-1));
    assign top_more = (top_idx != RW'(ROWS-1));
    assign bot_more = (bot_idx != '0);

    // The START-cycle issue needs column 0; in SERVE we always look one column ahead.
    assign col_sel = (state == SERVE) ? col_nx : '0;

    always_comb begin
        col_data = '0;
        for (int r = 0; r < ROWS; r++)
            col_data[r] = bmp[r][col_sel];
    end

    // Buffer contents are don't-care after reset, so no reset term here.
    always_ff @(posedge clk) begin
        if (wr_vld)
            bmp[wr_row] <= mem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            mem_rd          <= 1'b0;
            mem_addr        <= '0;
            rd_row          <= '0;
            wr_row          <= '0;
            wr_vld          <= 1'b0;
            alu_start       <= 1'b0;
            bitcolumn       <= '0;
            bitrowtop       <= '0;
            bitrowbot       <= '0;
            nextcolumnready <= 1'b0;
            nextrowtopready <= 1'b0;
            nextrowbotready <= 1'b0;
            lastcolumn      <= 1'b0;
            result          <= '0;
            done            <= 1'b0;
            col_idx         <= '0;
            top_idx         <= '0;
            bot_idx         <= RW'(ROWS-1);
            col_arm         <= 1'b0;
            top_arm         <= 1'b0;
            bot_arm         <= 1'b0;
        end else begin
            mem_rd          <= 1'b0;
            alu_start       <= 1'b0;
            nextcolumnready <= 1'b0;
            nextrowtopready <= 1'b0;
            nextrowbotready <= 1'b0;
            done            <= 1'b0;
            // Read data returns one cycle after the strobe; track which row it belongs to.
            wr_vld          <= mem_rd;
            wr_row          <= rd_row;

            case (state)
                IDLE: begin
                    if (go) begin
                        mem_rd   <= 1'b1;
                        mem_addr <= base_addr;
                        rd_row   <= '0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (mem_rd && rd_row != RW'(ROWS-1)) begin
                        mem_rd   <= 1'b1;
                        mem_addr <= mem_addr + 1'b1;
                        rd_row   <= rd_row + 1'b1;
                    end
                    if (wr_vld && wr_row == RW'(ROWS-1)) begin
                        alu_start <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    state           <= SERVE;
                    col_idx         <= '0;
                    top_idx         <= '0;
                    bot_idx         <= RW'(ROWS-1);
                    bitcolumn       <= col_data;
                    bitrowtop       <= bmp[0];
                    bitrowbot       <= bmp[ROWS-1];
                    nextcolumnready <= 1'b1;
                    nextrowtopready <= 1'b1;
                    nextrowbotready <= 1'b1;
                    lastcolumn      <= (COLS == 1);
                    col_arm         <= 1'b0;
                    top_arm         <= 1'b0;
                    bot_arm         <= 1'b0;
                end
                SERVE: begin
                    if (alu_done) begin
                        result     <= alu_result;
                        done       <= 1'b1;
                        lastcolumn <= 1'b0;
                        col_idx    <= '0;
                        top_idx    <= '0;
                        bot_idx    <= RW'(ROWS-1);
                        state      <= IDLE;
                    end else begin
                        // A stream re-arms only after its request is seen low, so a
                        // request still held from the previous consume is not re-served.
                        if (!nextcolumn)
                            col_arm <= 1'b1;
                        else if (col_arm && col_more) begin
                            col_idx         <= col_nx;
                            bitcolumn       <= col_data;
                            nextcolumnready <= 1'b1;
                            col_arm         <= 1'b0;
                            if (col_nx == CW'(COLS-1))
                                lastcolumn <= 1'b1;
                        end

                        if (!nextrowtop)
                            top_arm <= 1'b1;
                        else if (top_arm && top_more) begin
                            top_idx         <= top_nx;
                            bitrowtop       <= bmp[top_nx];
                            nextrowtopready <= 1'b1;
                            top_arm         <= 1'b0;
                        end

                        if (!nextrowbot)
                            bot_arm <= 1'b1;
                        else if (bot_arm && bot_more) begin
                            bot_idx         <= bot_nx;
                            bitrowbot       <= bmp[bot_nx];
                            nextrowbotready <= 1'b1;
                            bot_arm         <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bitmap_slice_feeder.sv
// Randomised bench for bitmap_slice_feeder: a pass-timeline model predicts every
// output each cycle, with literal spot checks on the walking and zero bitmaps.
module tb_bitmap_slice_feeder;
    localparam int ROWS = 64;
    localparam int COLS = 24;
    localparam int AW   = 16;
    localparam int K_START = ROWS + 1;  // edges after go until alu_start shows
    localparam int K_ISSUE = ROWS + 2;  // edges after go until first slice issue

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            go = 1'b0;
    logic [AW-1:0]   base_addr = '0;
    logic            mem_rd;
    logic [AW-1:0]   mem_addr;
    logic [COLS-1:0] mem_rdata = '0;
    logic            alu_start;
    logic [ROWS-1:0] bitcolumn;
    logic [COLS-1:0] bitrowtop, bitrowbot;
    logic            nextcolumnready, nextrowtopready, nextrowbotready, lastcolumn;
    logic            nextcolumn = 1'b0, nextrowtop = 1'b0, nextrowbot = 1'b0;
    logic            alu_done = 1'b0;
    logic [15:0]     alu_result = '0;
    logic [15:0]     result;
    logic            done;

    bitmap_slice_feeder #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .base_addr(base_addr),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .alu_start(alu_start), .bitcolumn(bitcolumn), .bitrowtop(bitrowtop),
        .bitrowbot(bitrowbot), .nextcolumnready(nextcolumnready),
        .nextrowtopready(nextrowtopready), .nextrowbotready(nextrowbotready),
        .lastcolumn(lastcolumn), .nextcolumn(nextcolumn), .nextrowtop(nextrowtop),
        .nextrowbot(nextrowbot), .alu_done(alu_done), .alu_result(alu_result),
        .result(result), .done(done)
    );

    always #5 clk = ~clk;

    logic [COLS-1:0] mem [0:1023];
    always @(posedge clk)
        mem_rdata <= mem_rd ? mem[mem_addr[9:0]] : COLS'($urandom);

    int n_chk = 0, n_fail = 0;
    int n_colp = 0, n_start = 0;

    logic [COLS-1:0] bm [ROWS];
    bit              m_busy;
    int              m_k, m_col, m_top, m_bot;
    bit              m_arm_c, m_arm_t, m_arm_b;
    logic [AW-1:0]   m_base;
    logic            e_mem_rd, e_start, e_rc, e_rt, e_rb, e_last, e_done;
    logic [AW-1:0]   e_addr;
    logic [15:0]     e_result;
    logic [ROWS-1:0] e_col;
    logic [COLS-1:0] e_top, e_bot;

    function automatic logic [ROWS-1:0] col_of(input int c);
        logic [ROWS-1:0] v;
        for (int r = 0; r < ROWS; r++) v[r] = bm[r][c];
        return v;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_k = 0; m_col = 0; m_top = 0; m_bot = ROWS - 1;
        m_arm_c = 0; m_arm_t = 0; m_arm_b = 0;
        e_mem_rd = 0; e_addr = '0; e_start = 0; e_rc = 0; e_rt = 0; e_rb = 0;
        e_last = 0; e_done = 0; e_result = '0; e_col = '0; e_top = '0; e_bot = '0;
    endtask

    // One clock edge of the pass timeline, from the inputs present at that edge.
    task automatic model_step();
        e_mem_rd = 0; e_start = 0; e_rc = 0; e_rt = 0; e_rb = 0; e_done = 0;
        if (!m_busy) begin
            if (go) begin m_busy = 1; m_k = 0; m_base = base_addr; end
        end else begin
            m_k++;
            if (m_k > K_ISSUE && alu_done) begin
                e_result = alu_result; e_done = 1; m_busy = 0; e_last = 0;
                m_col = 0; m_top = 0; m_bot = ROWS - 1;
            end else if (m_k == K_ISSUE) begin
                m_col = 0; m_top = 0; m_bot = ROWS - 1;
                e_col = col_of(0); e_top = bm[0]; e_bot = bm[ROWS-1];
                e_rc = 1; e_rt = 1; e_rb = 1; e_last = (m_col == COLS - 1);
                m_arm_c = 0; m_arm_t = 0; m_arm_b = 0;
            end else if (m_k > K_ISSUE) begin
                if (!nextcolumn) m_arm_c = 1;
                else if (m_arm_c && m_col < COLS - 1) begin
                    m_col++; e_col = col_of(m_col); e_rc = 1; m_arm_c = 0;
                    if (m_col == COLS - 1) e_last = 1;
                end
                if (!nextrowtop) m_arm_t = 1;
                else if (m_arm_t && m_top < ROWS - 1) begin
                    m_top++; e_top = bm[m_top]; e_rt = 1; m_arm_t = 0;
                end
                if (!nextrowbot) m_arm_b = 1;
                else if (m_arm_b && m_bot > 0) begin
                    m_bot--; e_bot = bm[m_bot]; e_rb = 1; m_arm_b = 0;
                end
            end
        end
        if (m_busy && m_k <= ROWS - 1) begin e_mem_rd = 1; e_addr = m_base + AW'(m_k); end
        if (m_busy && m_k == K_START) e_start = 1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("mem_rd", 64'(mem_rd), 64'(e_mem_rd));
        if (e_mem_rd) chk("mem_addr", 64'(mem_addr), 64'(e_addr));
        chk("alu_start", 64'(alu_start), 64'(e_start));
        chk("colready", 64'(nextcolumnready), 64'(e_rc));
        chk("topready", 64'(nextrowtopready), 64'(e_rt));
        chk("botready", 64'(nextrowbotready), 64'(e_rb));
        chk("bitcolumn", 64'(bitcolumn), 64'(e_col));
        chk("bitrowtop", 64'(bitrowtop), 64'(e_top));
        chk("bitrowbot", 64'(bitrowbot), 64'(e_bot));
        chk("lastcolumn", 64'(lastcolumn), 64'(e_last));
        chk("done", 64'(done), 64'(e_done));
        chk("result", 64'(result), 64'(e_result));
        if (nextcolumnready) n_colp++;
        if (alu_start) n_start++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic set_reqs(input logic c, input logic t, input logic b);
        nextcolumn = c; nextrowtop = t; nextrowbot = b;
    endtask

    // kind 0: walking bit per row, 1: all zero, 2: random
    task automatic start_pass(input logic [AW-1:0] b, input int kind);
        for (int r = 0; r < ROWS; r++) begin
            case (kind)
                0:       bm[r] = COLS'(1) << (r % COLS);
                1:       bm[r] = '0;
                default: bm[r] = COLS'($urandom);
            endcase
            mem[(int'(b) + r) % 1024] = bm[r];
        end
        base_addr = b; go = 1'b1;
        tick();
        go = 1'b0; base_addr = AW'($urandom);
    endtask

    task automatic run_to_issue();
        for (int i = 0; i < 200 && !(m_busy && m_k == K_ISSUE); i++) tick();
        chk("reach_issue", 64'(m_busy && m_k == K_ISSUE), 64'(1));
    endtask

    initial begin
        bit seen;
        model_reset();
        #1 compare_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Pass 1: walking bitmap at 0x0100
        n_start = 0;
        start_pass(16'h0100, 0);
        run_to_issue();
        chk("lit_first_top", 64'(bitrowtop), 64'h000001);
        chk("lit_first_bot", 64'(bitrowbot), 64'h008000);
        chk("lit_first_col", 64'(bitcolumn), 64'h0001000001000001);
        chk("lit_start_once", 64'(n_start), 64'(1));
        n_colp = 1;
        set_reqs(0, 0, 0); tick();
        set_reqs(1, 1, 1); tick();
        chk("lit_mixed_pulses", 64'({nextcolumnready, nextrowtopready, nextrowbotready}), 64'h7);
        chk("lit_mixed_top", 64'(bitrowtop), 64'h000002);
        chk("lit_mixed_bot", 64'(bitrowbot), 64'h004000);
        chk("lit_mixed_col", 64'(bitcolumn), 64'h0002000002000002);
        for (int i = 0; i < 150; i++) begin
            set_reqs(i[0], i[0], i[0]);
            go = 1'($urandom);
            tick();
        end
        chk("lit_col_pulses", 64'(n_colp), 64'(24));
        chk("lit_lastcolumn", 64'(lastcolumn), 64'(1));
        for (int i = 0; i < 100; i++) begin
            set_reqs(1'($urandom), 1'($urandom), 1'($urandom));
            go = 1'($urandom);
            tick();
        end
        go = 1'b0;
        alu_done = 1'b1; alu_result = 16'($urandom);
        tick();
        alu_done = 1'b0;
        repeat (3) tick();

        // Pass 2: all-zero bitmap, ALU reports 16'h1FB8
        start_pass(16'h0200, 1);
        for (int i = 0; i < 200 && !(m_busy && m_k == K_ISSUE); i++) begin
            alu_done = 1'($urandom);
            tick();
        end
        alu_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            set_reqs(1'($urandom), 1'($urandom), 1'($urandom));
            tick();
        end
        alu_done = 1'b1; alu_result = 16'h1FB8;
        tick();
        alu_done = 1'b0;
        chk("lit_done", 64'(done), 64'(1));
        chk("lit_result", 64'(result), 64'h1FB8);

        // Pass 3: accepted straight after done, reset at row 30 of the load
        start_pass(16'h02C0, 2);
        for (int i = 0; i < 100 && m_k < 30; i++) tick();
        chk("lit_row30_addr", 64'(mem_addr), 64'h02C0 + 64'd30);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("lit_rst_mem_rd", 64'(mem_rd), 64'(0));
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_reqs(1'($urandom), 1'($urandom), 1'($urandom));
            alu_done = 1'($urandom);
            tick();
        end
        alu_done = 1'b0;

        // Pass 4: fully random traffic until the ALU finishes
        start_pass(16'h0340, 2);
        seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            set_reqs(1'($urandom), 1'($urandom), 1'($urandom));
            go = 1'($urandom);
            alu_done = ($urandom_range(99) == 0);
            alu_result = 16'($urandom);
            tick();
            if (e_done) seen = 1;
        end
        go = 1'b0; alu_done = 1'b0;
        chk("pass4_done_seen", 64'(seen), 64'(1));
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bitmap_slice_feeder.md
Name: bitmap_slice_feeder

Overview:
- Transmit end of the bitmap-slice interface consumed by the compare ALU (cmpalu).
- Loads a 64-row x 24-column bitmap from row-organised memory into an internal buffer.
- Serves three independent slice streams on request: columns left-to-right (64-bit), rows top-down (24-bit), rows bottom-up (24-bit).
- Pulses the ALU start, waits for the ALU's done, captures its 16-bit result and reports completion to the sequencer.

Parameters:
- ROWS, 64: bitmap height; column slice width; 6-bit row indices.
- COLS, 24: bitmap width; row slice width; 5-bit column index.
- AW, 16: memory word-address width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- go  in  1  begin one pass; sampled only in IDLE.
- base_addr  in  AW  word address of bitmap row 0; captured on go.
- mem_rd  out  1  memory read strobe.
- mem_addr  out  AW  read address.
- mem_rdata  in  COLS  read data; valid exactly 1 cycle after mem_rd.
- alu_start  out  1  one-cycle reset/start pulse to the ALU.
- bitcolumn  out  ROWS  current column slice; bit r = buffer row r, bit c.
- bitrowtop  out  COLS  current top-stream row.
- bitrowbot  out  COLS  current bottom-stream row.
- nextcolumnready  out  1  one-cycle pulse: new bitcolumn valid.
- nextrowtopready  out  1  one-cycle pulse: new bitrowtop valid.
- nextrowbotready  out  1  one-cycle pulse: new bitrowbot valid.
- lastcolumn  out  1  level: column COLS-1 has been issued.
- nextcolumn  in  1  ALU request for next column (level).
- nextrowtop  in  1  ALU request for next top row (level).
- nextrowbot  in  1  ALU request for next bottom row (level).
- alu_done  in  1  ALU finished.
- alu_result  in  16  ALU result; valid while alu_done is high.
- result  out  16  captured ALU result.
- done  out  1  one-cycle pulse when result is captured.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - Outputs: mem_rd, alu_start, all ready pulses, lastcolumn, done = 0; result = 0; bitcolumn/bitrowtop/bitrowbot = 0.
  - Stream indices cleared: column 0, top 0, bottom ROWS-1.
  - Reset mid-pass abandons the pass; the buffer contents are don't-care.
- IDLE:
  - go=1 captures base_addr and moves to LOAD.
  - go is ignored in every other state.
- LOAD:
  - Reads issue on consecutive cycles: mem_rd=1, mem_addr=base+r for r=0..ROWS-1.
  - mem_rdata is written into buffer row r one cycle after each read.
  - On the cycle after the last data write (65 cycles after entry), move to START.
- START:
  - alu_start=1 for exactly one cycle, then SERVE.
- SERVE, first cycle (unsolicited issue):
  - Drive column 0, top row 0 and bottom row ROWS-1.
  - Pulse all three ready signals together.
- SERVE, per-stream handshake (column, top and bottom streams are independent):
  - Each stream has an ARMED flag, cleared on issue.
  - The flag re-arms on the first cycle its request input is sampled low. This absorbs the ALU's request still being high in the cycle its ready is consumed.
  - Request high while ARMED, with items remaining: advance the index, drive the new data, pulse ready for 1 cycle; latency is 1 clock from the request edge.
  - Data outputs hold steady between pulses.
- Stream exhaustion:
  - Column stream ends after column COLS-1.
  - Top stream ends after row ROWS-1.
  - Bottom stream ends after row 0.
  - After exhaustion, further requests are ignored: no pulse, data held, index saturates with no wrap.
- lastcolumn:
  - Rises in the same cycle as the ready pulse for column COLS-1.
  - Stays high until the block leaves SERVE.
- Completion:
  - alu_done sampled high in SERVE: result<=alu_result, done=1 for one cycle, return to IDLE.
  - Outstanding requests are dropped; lastcolumn and the indices clear.
- Simultaneous requests on two or three streams are each served in the same cycle.

Test Plan:
- Walking bitmap, row r = 24'h1<<(r%24), go with base=0x0100 → mem_addr 0x0100..0x013F over 64 cycles; alu_start pulses once; first-cycle bitrowtop=24'h000001, bitrowbot=row 63 = 24'h008000, bitcolumn=64'h0001000001000001.
- Hold nextcolumn high continuously → exactly one nextcolumnready per low-high cycle of the request, never back-to-back; 24th column pulse raises lastcolumn, which stays high; a 25th request gives no pulse.
- Mixed requests: top and bottom requested on the same cycle as a column request → all three pulse together; indices become top 1, bottom 62, column 1.
- All-zero bitmap with an ALU model asserting alu_done and alu_result=16'h1FB8 → done pulses once, result=16'h1FB8, state returns to IDLE, a new go is accepted.
- rst_n low in mid-LOAD (row 30) → mem_rd=0 immediately; after release, go restarts from row 0 and no stray ready pulses appear.
- go asserted during SERVE → ignored; pass completes normally.
